mt19937_untemper_capture: RTL and testbench

Inverse of the mt19937 output tempering. Accepts a stream of 32-bit tempered outputs over a valid/ready handshake and inverts the tempering to recover raw state words. Forwards the recovered words downstream and captures the first NUM_WORDS of them in a buffer, so that a generator's 624-word state can be reconstructed and read back. Sits on the consumer side of an mt19937 generator in RNG test/characterisation harnesses.

---
 rtl/mt19937_untemper_pkg.sv | 20 ++
 rtl/mt19937_untemper.sv | 34 +++
 rtl/mt19937_untemper_capture.sv | 139 +++++++++++++
 tb/tb_mt19937_untemper_capture.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mt19937_untemper_pkg.sv
// Shared mt19937 tempering constants and capture-FSM types.
// Consumed by the generator side and by the untemper/capture block.
package mt19937_untemper_pkg;

    localparam int NUM_WORDS_DEF = 624;

    localparam logic [31:0] TEMPER_B = 32'h9d2c5680;
    localparam logic [31:0] TEMPER_C = 32'hefc60000;

    localparam int SHIFT_U = 11;
    localparam int SHIFT_S = 7;
    localparam int SHIFT_T = 15;
    localparam int SHIFT_L = 18;

    typedef enum logic {
        CAP_RUN,
        CAP_FULL
    } cap_state_e;

endpackage

// File: rtl/mt19937_untemper.sv
// Combinational mt19937 untemper y -> w, split at a and c so a caller
// may register those points (a_tap/c_tap feed the following step).
module mt19937_untemper
    import mt19937_untemper_pkg::*;
#(
    parameter logic [31:0] C1 = TEMPER_B,
    parameter logic [31:0] C2 = TEMPER_C
) (
    input  logic [31:0] y,
    output logic [31:0] a,
    input  logic [31:0] a_tap,
    output logic [31:0] c,
    input  logic [31:0] c_tap,
    output logic [31:0] w
);

    logic [31:0] b;
    logic [31:0] x1, x2, x3;
    logic [31:0] w1;

    assign a = y ^ (y >> SHIFT_L);

    assign b = a_tap ^ ((a_tap << SHIFT_T) & C2);

    // Each pass recovers 7 more bits; four passes cover all 32.
    assign x1 = b ^ ((b  << SHIFT_S) & C1);
    assign x2 = b ^ ((x1 << SHIFT_S) & C1);
    assign x3 = b ^ ((x2 << SHIFT_S) & C1);
    assign c  = b ^ ((x3 << SHIFT_S) & C1);

    assign w1 = c_tap ^ (c_tap >> SHIFT_U);
    assign w  = c_tap ^ (w1 >> SHIFT_U);

endmodule

// File: rtl/mt19937_untemper_capture.sv
// Untempers an mt19937 output stream and captures the recovered state.
// Define MT19937_UNTEMPER_PIPE_EN for a 3-stage untemper pipeline.
module mt19937_untemper_capture
    import mt19937_untemper_pkg::*;
#(
    parameter int          NUM_WORDS = NUM_WORDS_DEF,
    parameter logic [31:0] C1        = TEMPER_B,
    parameter logic [31:0] C2        = TEMPER_C,
    localparam int         CW        = $clog2(NUM_WORDS + 1),
    localparam int         AW        = $clog2(NUM_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_rnd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_word,
    output logic [CW-1:0] cap_count,
    output logic          cap_done,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    localparam logic [CW-1:0] LAST_CNT  = CW'(NUM_WORDS - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);

    logic [31:0] a, c, w;
    logic [31:0] a_tap, c_tap;
    logic        out_en;
    logic        v_last;
    logic        out_fire;
    logic        wr_en;
    cap_state_e  state;
    logic [31:0] buffer [NUM_WORDS];

    mt19937_untemper #(
        .C1(C1),
        .C2(C2)
    ) u_untemper (
        .y    (in_rnd),
        .a    (a),
        .a_tap(a_tap),
        .c    (c),
        .c_tap(c_tap),
        .w    (w)
    );

    assign out_en = !out_valid || out_ready;

`ifdef MT19937_UNTEMPER_PIPE_EN
    logic        v1, v2;
    logic [31:0] a_q, c_q;
    logic        en1, en2;

    assign en2      = !v2 || out_en;
    assign en1      = !v1 || en2;
    assign in_ready = en1;
    assign a_tap    = a_q;
    assign c_tap    = c_q;
    assign v_last   = v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            a_q <= '0;
            c_q <= '0;
        end else begin
            if (en1) begin
                v1 <= in_valid;
                if (in_valid) a_q <= a;
            end
            if (en2) begin
                v2 <= v1;
                if (v1) c_q <= c;
            end
        end
    end
`else
    assign in_ready = out_en;
    assign a_tap    = a;
    assign c_tap    = c;
    assign v_last   = in_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_word  <= '0;
        end else if (out_en) begin
            out_valid <= v_last;
            if (v_last) out_word <= w;
        end
    end

    assign out_fire = out_valid && out_ready;
    // clear beats a coincident capture; the word still goes downstream.
    assign wr_en    = out_fire && !clear && (state == CAP_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CAP_RUN;
            cap_count <= '0;
            cap_done  <= 1'b0;
        end else begin
            unique case (1'b1)
                clear: begin
                    state     <= CAP_RUN;
                    cap_count <= '0;
                    cap_done  <= 1'b0;
                end
                wr_en: begin
                    cap_count <= cap_count + 1'b1;
                    if (cap_count == LAST_CNT) begin
                        state    <= CAP_FULL;
                        cap_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) buffer[cap_count[AW-1:0]] <= out_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= (rd_addr <= LAST_ADDR) ? buffer[rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_mt19937_untemper_capture.sv
// Bench for mt19937_untemper_capture: streaming, capture, clear, reset.
// Honours MT19937_UNTEMPER_PIPE_EN for the expected latency.
module tb_mt19937_untemper_capture;

    localparam int N = 624;
`ifdef MT19937_UNTEMPER_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rnd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [9:0]  cap_count;
    logic        cap_done;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data;

    mt19937_untemper_capture dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_rnd   (in_rnd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word (out_word),
        .cap_count(cap_count),
        .cap_done (cap_done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] send_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] mt[N];
    logic [31:0] mem_model[N];
    int          m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] temper(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y >> 11);
        y = y ^ ((y << 7) & 32'h9d2c5680);
        y = y ^ ((y << 15) & 32'hefc60000);
        y = y ^ (y >> 18);
        return y;
    endfunction

    task automatic mt_seed(input logic [31:0] s);
        mt[0] = s;
        for (int i = 1; i < N; i++)
            mt[i] = 32'd1812433253 * (mt[i-1] ^ (mt[i-1] >> 30)) + 32'(i);
    endtask

    task automatic mt_twist();
        logic [31:0] y;
        for (int i = 0; i < N; i++) begin
            y = (mt[i] & 32'h80000000) | (mt[(i + 1) % N] & 32'h7fffffff);
            mt[i] = mt[(i + 397) % N] ^ (y >> 1)
                  ^ (y[0] ? 32'h9908b0df : 32'h0);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_cnt = 0;
        chk("clear_count", cap_count, 0);
        chk("clear_done", cap_done, 0);
    endtask

    task automatic single(input logic [31:0] rnd, input logic [31:0] exp,
                          input string tag);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        in_rnd    = rnd;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_word"}, out_word, exp);
    endtask

    task automatic stream(input int n, input bit bp, input int clr_at,
                          input string tag);
        int          recv;
        int          cyc;
        bit          stall;
        bit          fire;
        logic [31:0] held;
        logic [31:0] e;
        recv  = 0;
        cyc   = 0;
        stall = 1'b0;
        held  = '0;
        while (recv < n && cyc < 20 * n + 100) begin
            @(negedge clk);
            clear = 1'b0;
            if (bp) begin
                out_ready = ($urandom_range(3) != 0);
                in_valid  = (send_q.size() > 0) && ($urandom_range(3) != 0);
            end else begin
                out_ready = 1'b1;
                in_valid  = (send_q.size() > 0);
            end
            in_rnd = in_valid ? temper(send_q[0]) : $urandom;
            #1;
            if (stall) begin
                chk({tag, "_stall_valid"}, out_valid, 1);
                chk({tag, "_stall_word"}, out_word, held);
            end
            chk({tag, "_in_ready"}, in_ready || (out_valid && !out_ready), 1);
            chk({tag, "_cap_count"}, cap_count, m_cnt);
            chk({tag, "_cap_done"}, cap_done, m_cnt == N);
            fire = out_valid && out_ready;
            if (fire) begin
                n_assert++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL %s_extra: observed %h expected none",
                           tag, out_word);
                end
                e = (exp_q.size() > 0) ? exp_q.pop_front() : ~out_word;
                chk({tag, "_out_word"}, out_word, e);
                if (recv == clr_at) begin
                    clear = 1'b1;
                    m_cnt = 0;
                end else if (m_cnt < N) begin
                    mem_model[m_cnt] = e;
                    m_cnt++;
                end
                recv++;
            end
            stall = out_valid && !out_ready;
            held  = out_word;
            if (in_valid && in_ready) exp_q.push_back(send_q.pop_front());
            cyc++;
        end
        chk({tag, "_received"}, recv, n);
        if (!bp) chk({tag, "_throughput"}, cyc, n + LAT);
        @(negedge clk);
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic read_chk(input int addr, input logic [31:0] exp,
                            input string tag);
        @(negedge clk);
        rd_addr = 10'(addr);
        @(negedge clk);
        chk(tag, rd_data, exp);
    endtask

    initial begin
        logic [31:0] x;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_rnd    = '0;
        rd_addr   = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_word", out_word, 0);
        chk("rst_cap_count", cap_count, 0);
        chk("rst_cap_done", cap_done, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;

        single(32'h88102204, 32'h80000000, "single_msb");
        single(32'h0, 32'h0, "single_zero");
        pulse_clear();

        for (int i = 0; i < 10000; i++) send_q.push_back($urandom);
        stream(10000, 1'b0, -1, "roundtrip");

        for (int i = 0; i < 2000; i++) send_q.push_back($urandom);
        stream(2000, 1'b1, -1, "backpress");

        pulse_clear();
        mt_seed(32'd5489);
        mt_twist();
        for (int i = 0; i < N; i++) send_q.push_back(mt[i]);
        stream(N, 1'b0, -1, "capture");
        chk("capture_count", cap_count, N);
        chk("capture_done", cap_done, 1);
        for (int i = 0; i < N; i++) read_chk(i, mt[i], "readback");
        read_chk(700, 0, "read_oob_700");
        read_chk(1023, 0, "read_oob_1023");

        send_q.push_back($urandom);
        stream(1, 1'b0, -1, "word625");
        chk("word625_count", cap_count, N);
        chk("word625_done", cap_done, 1);
        read_chk(0, mt[0], "word625_buf0");
        read_chk(N - 1, mt[N-1], "word625_buf_last");

        pulse_clear();
        for (int i = 0; i < 150; i++) send_q.push_back($urandom);
        stream(150, 1'b1, 99, "clear_mid");
        chk("clear_mid_count", cap_count, 50);
        for (int i = 0; i < 130; i++) read_chk(i, mem_model[i], "clear_buf");

        @(negedge clk);
        x         = $urandom;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_rnd    = temper(x);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        chk("arst_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_cap_count", cap_count, 0);
        chk("arst_cap_done", cap_done, 0);
        chk("arst_rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 0;
        x = $urandom;
        single(temper(x), x, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
